// File: rtl/fib_inv_if.sv
// Request/response bundle for fib_inv: start/v in, ready/done_tick and result fields out.
// The master side issues requests and the slave side (the FSMD) answers them.
interface fib_inv_if;
   logic        start;
   logic [19:0] v;
   logic        ready;
   logic        done_tick;
   logic [4:0]  n;
   logic [19:0] fn;
   logic [19:0] rem;
   logic        exact;

   modport master (
      output start, v,
      input  ready, done_tick, n, fn, rem, exact
   );

   modport slave (
      input  start, v,
      output ready, done_tick, n, fn, rem, exact
   );
endinterface

// File: rtl/fib_inv.sv
// Inverse-Fibonacci FSMD: finds the largest n with fib(n) <= v.
// It reports n, fib(n), the remainder and an exact-match flag, using a start/ready/done_tick handshake.
module fib_inv (
   input  logic     clk,
   input  logic     reset_n,
   fib_inv_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OP   = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      r_state, w_stateNext;
   logic [19:0] r_v, w_vNext;
   logic [20:0] r_t0, w_t0Next;
   logic [20:0] r_t1, w_t1Next;
   logic [20:0] w_sum;
   logic [4:0]  r_n, w_nNext;
   logic [19:0] r_rem, w_remNext;
   logic        r_exact, w_exactNext;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v     <= 20'd0;
         r_t0    <= 21'd0;
         r_t1    <= 21'd0;
         r_n     <= 5'd0;
         r_rem   <= 20'd0;
         r_exact <= 1'b0;
      end else begin
         r_v     <= w_vNext;
         r_t0    <= w_t0Next;
         r_t1    <= w_t1Next;
         r_n     <= w_nNext;
         r_rem   <= w_remNext;
         r_exact <= w_exactNext;
      end
   end

   // t1 tracks fib(n); t0 trails one step behind so their sum is fib(n+1).
   always_comb begin
      w_stateNext = r_state;
      w_vNext     = r_v;
      w_t0Next    = r_t0;
      w_t1Next    = r_t1;
      w_nNext     = r_n;
      w_remNext   = r_rem;
      w_exactNext = r_exact;
      w_sum       = r_t0 + r_t1;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_vNext = bus.v;
               if (bus.v == 20'd0) begin
                  w_t0Next    = 21'd0;
                  w_t1Next    = 21'd0;
                  w_nNext     = 5'd0;
                  w_remNext   = 20'd0;
                  w_exactNext = 1'b1;
                  w_stateNext = DONE;
               end else begin
                  w_t0Next    = 21'd0;
                  w_t1Next    = 21'd1;
                  w_nNext     = 5'd1;
                  w_stateNext = OP;
               end
            end
         end
         OP: begin
            if (w_sum <= {1'b0, r_v}) begin
               w_t0Next = r_t1;
               w_t1Next = w_sum;
               w_nNext  = r_n + 5'd1;
            end else begin
               w_remNext   = r_v - r_t1[19:0];
               w_exactNext = (r_v == r_t1[19:0]);
               w_stateNext = DONE;
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign bus.ready     = (r_state == IDLE);
   assign bus.done_tick = (r_state == DONE);
   assign bus.n         = r_n;
   assign bus.fn        = r_t1[19:0];
   assign bus.rem       = r_rem;
   assign bus.exact     = r_exact;

endmodule

// File: tb/tb_fib_inv.sv
// Self-checking bench for fib_inv: a table-driven reference model checked every cycle,
// plus directed requests pinned to hand-computed results.
module tb_fib_inv;

   logic clk;
   logic reset_n;
   int   vectors     = 0;
   int   miscompares = 0;

   fib_inv_if bus ();

   fib_inv dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkValue(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: fib table lookup, largest index whose value does not exceed val.
   function automatic void modelInvert(input int val, output int n, output int f);
      int tab[32];
      tab[0] = 0;
      tab[1] = 1;
      for (int i = 2; i < 32; i++) tab[i] = tab[i-1] + tab[i-2];
      n = 0;
      for (int i = 0; i < 32; i++) if (tab[i] <= val) n = i;
      f = tab[n];
   endfunction

   int mBusy = 0;
   int mCyc, mDoneAt;
   int pN, pF, pR, pE;
   int hN = 0, hF = 0, hR = 0, hE = 0;

   // Cycle-level model of the handshake, driven only by the inputs the bench applies.
   always @(negedge clk) begin
      if (!reset_n) begin
         mBusy = 0;
         hN = 0; hF = 0; hR = 0; hE = 0;
         checkValue("rst_ready", int'(bus.ready), 1);
         checkValue("rst_done", int'(bus.done_tick), 0);
         checkValue("rst_n", int'(bus.n), 0);
         checkValue("rst_fn", int'(bus.fn), 0);
         checkValue("rst_rem", int'(bus.rem), 0);
         checkValue("rst_exact", int'(bus.exact), 0);
      end else begin
         int expDone;
         if (mBusy != 0) begin
            mCyc++;
            if (mCyc == mDoneAt + 1) mBusy = 0;
         end
         expDone = (mBusy != 0 && mCyc == mDoneAt) ? 1 : 0;
         if (expDone != 0) begin
            hN = pN; hF = pF; hR = pR; hE = pE;
         end
         checkValue("ready", int'(bus.ready), (mBusy == 0) ? 1 : 0);
         checkValue("done_tick", int'(bus.done_tick), expDone);
         if (mBusy == 0 || expDone != 0) begin
            checkValue("model_n", int'(bus.n), hN);
            checkValue("model_fn", int'(bus.fn), hF);
            checkValue("model_rem", int'(bus.rem), hR);
            checkValue("model_exact", int'(bus.exact), hE);
         end
         if (mBusy == 0 && bus.start === 1'b1) begin
            int val;
            val = int'(bus.v);
            modelInvert(val, pN, pF);
            pR      = val - pF;
            pE      = (pR == 0) ? 1 : 0;
            mDoneAt = (val == 0) ? 1 : pN + 1;
            mCyc    = 0;
            mBusy   = 1;
         end
      end
   end

   task automatic applyStimulus(input logic [19:0] val);
      bit seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkValue("wait_ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.v     = val;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic checkOutput(input int lat, input int expN, input int expFn, input int expRem,
                              input int expExact, input int gCyc, input logic [19:0] gV);
      bit seen    = 0;
      int doneCyc = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == gCyc) begin
            bus.v     = gV;
            bus.start = 1'b1;
         end else if (c == gCyc + 1) begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (bus.done_tick === 1'b1) begin
            seen    = 1;
            doneCyc = c;
            break;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      if (!seen) begin
         checkValue("done_timeout", 0, 1);
      end else begin
         checkValue("lit_latency", doneCyc, lat);
         checkValue("lit_n", int'(bus.n), expN);
         checkValue("lit_fn", int'(bus.fn), expFn);
         checkValue("lit_rem", int'(bus.rem), expRem);
         checkValue("lit_exact", int'(bus.exact), expExact);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.v     = 20'd0;
      #3;
      checkValue("init_ready", int'(bus.ready), 1);
      checkValue("init_n", int'(bus.n), 0);
      checkValue("init_exact", int'(bus.exact), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      applyStimulus(20'd0);       checkOutput(1, 0, 0, 0, 1, -10, 20'd0);
      applyStimulus(20'd1);       checkOutput(3, 2, 1, 0, 1, -10, 20'd0);
      applyStimulus(20'd2);       checkOutput(4, 3, 2, 0, 1, -10, 20'd0);
      applyStimulus(20'd100);     checkOutput(12, 11, 89, 11, 0, -10, 20'd0);
      applyStimulus(20'd832040);  checkOutput(31, 30, 832040, 0, 1, -10, 20'd0);
      applyStimulus(20'd1048575); checkOutput(31, 30, 832040, 216535, 0, -10, 20'd0);

      // A start pulse while busy must be dropped, not queued.
      applyStimulus(20'd100);     checkOutput(12, 11, 89, 11, 0, 4, 20'd5);
      repeat (3) begin
         @(negedge clk);
         checkValue("no_queued_done", int'(bus.done_tick), 0);
      end
      applyStimulus(20'd5);       checkOutput(6, 5, 5, 0, 1, -10, 20'd0);

      // Reset in cycle 4 of a request aborts it immediately.
      applyStimulus(20'd1000);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      checkValue("midop_ready", int'(bus.ready), 1);
      checkValue("midop_fn", int'(bus.fn), 0);
      checkValue("midop_n", int'(bus.n), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkValue("abort_no_done", int'(bus.done_tick), 0);
      end
      applyStimulus(20'd1000);    checkOutput(17, 16, 987, 13, 0, -10, 20'd0);

      // Start held high: one request per N+2 cycles, with v sampled in each idle cycle.
      @(posedge clk); #1;
      bus.start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.v = 20'((i * 7) % 23);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
